flash_boot_loader: RTL and testbench



---
 rtl/flash_boot_loader.sv | 200 ++++++++++++++++++++
 tb/tb_flash_boot_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_boot_loader.sv
// Boot sequencer: reads LOAD_LEN bytes from SPI flash (READ 0x03) into SRAM, holding the CPU in reset until done.
// Latency: 64*CLK_DIV+1 cycles of command overhead, then 16*CLK_DIV+1 cycles per byte with iWrAck tied high.
// Backpressure: oWrEn holds until iWrAck; SCK parks low meanwhile, so the continuous flash read just stretches.
// Ports: iClk / iRstN (synchronous, active-low);
//        oSpiCsN, oSpiSck, oSpiMosi, iSpiMiso - SPI mode 0 master towards the config flash;
//        oWrAddr, oWrData, oWrEn, iWrAck     - SRAM write request to the arbiter;
//        oCpuRst (high until the image is in SRAM), oDone (sticky until reset).
module flash_boot_loader #(
    parameter logic [23:0] FLASH_OFFSET = 24'h100000,
    parameter logic [19:0] LOAD_BASE    = 20'hFE000,
    parameter int unsigned LOAD_LEN     = 8192,
    parameter int unsigned CLK_DIV      = 2
) (
    input  logic        iClk,
    input  logic        iRstN,
    output logic        oSpiCsN,
    output logic        oSpiSck,
    output logic        oSpiMosi,
    input  logic        iSpiMiso,
    output logic [19:0] oWrAddr,
    output logic [7:0]  oWrData,
    output logic        oWrEn,
    input  logic        iWrAck,
    output logic        oCpuRst,
    output logic        oDone
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [20:0]      LEN      = 21'(LOAD_LEN);
    localparam logic [31:0]      CMD_WORD = {8'h03, FLASH_OFFSET};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state_q,   state_d;
    logic             cs_n_q,    cs_n_d;
    logic             sck_q,     sck_d;
    logic             mosi_q,    mosi_d;
    logic [19:0]      wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             wr_en_q,   wr_en_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             done_q,    done_d;
    logic [20:0]      cnt_q,     cnt_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [5:0]       bit_q,     bit_d;
    logic [31:0]      cmd_sr_q,  cmd_sr_d;
    logic [7:0]       rx_q,      rx_d;

    // One SCK half-period has elapsed; SCK toggles on this cycle.
    logic tick;
    assign tick = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = wr_en_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        cmd_sr_d  = cmd_sr_q;
        rx_d      = rx_q;

        case (state_q)
            S_IDLE: begin
                // CS falls together with the first command bit on MOSI.
                state_d  = S_CMD;
                cs_n_d   = 1'b0;
                sck_d    = 1'b0;
                cmd_sr_d = CMD_WORD;
                mosi_d   = CMD_WORD[31];
                div_d    = '0;
                bit_d    = '0;
            end

            S_CMD: begin
                if (tick) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (sck_q) begin
                        // Falling edge: the flash has sampled the current bit.
                        if (bit_q == 6'd31) begin
                            state_d = S_READ;
                            bit_d   = '0;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d    = bit_q + 6'd1;
                            mosi_d   = cmd_sr_q[30];
                            cmd_sr_d = {cmd_sr_q[30:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_READ: begin
                if (tick) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // Rising edge: MISO has been stable since the previous fall.
                        rx_d = {rx_q[6:0], iSpiMiso};
                    end else if (bit_q == 6'd7) begin
                        // 8th falling edge: SCK is now low and stays parked there in WRITE.
                        state_d   = S_WRITE;
                        bit_d     = '0;
                        wr_data_d = rx_q;
                        wr_en_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_WRITE: begin
                if (wr_en_q && iWrAck) begin
                    wr_en_d   = 1'b0;
                    wr_addr_d = wr_addr_q + 20'd1;
                    cnt_d     = cnt_q + 21'd1;
                    div_d     = '0;
                    if (cnt_q + 21'd1 == LEN) begin
                        state_d   = S_DONE;
                        cs_n_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_DONE: begin
                // Parked until reset; outputs already hold their final values.
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q   <= S_IDLE;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            wr_addr_q <= LOAD_BASE;
            wr_data_q <= 8'h00;
            wr_en_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            cmd_sr_q  <= '0;
            rx_q      <= '0;
        end else begin
            state_q   <= state_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            cmd_sr_q  <= cmd_sr_d;
            rx_q      <= rx_d;
        end
    end

    assign oSpiCsN  = cs_n_q;
    assign oSpiSck  = sck_q;
    assign oSpiMosi = mosi_q;
    assign oWrAddr  = wr_addr_q;
    assign oWrData  = wr_data_q;
    assign oWrEn    = wr_en_q;
    assign oCpuRst  = cpu_rst_q;
    assign oDone    = done_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: two instances (A: 64 bytes at FFFF0 wrapping past FFFFF, CLK_DIV=1;
// B: single byte at FE000, CLK_DIV=3) share clock and reset, each talking to its own SPI flash model.
// Expected SRAM contents come from image[j] -> (base + j) mod 2^20; timing from the per-byte cost formula.
module tb_flash_boot_loader;

    localparam int          N_A    = 64;
    localparam int          N_B    = 1;
    localparam int          CD_A   = 1;
    localparam int          CD_B   = 3;
    localparam logic [19:0] BASE_A = 20'hFFFF0;
    localparam logic [19:0] BASE_B = 20'hFE000;
    localparam logic [23:0] FOFF   = 24'h100000;

    logic             clk = 1'b0;
    logic             rstn;
    logic [1:0]       cs_n, sck, mosi, wr_en, ack, cpu_rst, done;
    logic [1:0][19:0] wr_addr;
    logic [1:0][7:0]  wr_data;

    logic [7:0]  img [256];
    logic [27:0] wlog [2][72];
    int          wcnt [2];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int          LEN  = (g == 0) ? N_A : N_B;
        localparam int          DIV  = (g == 0) ? CD_A : CD_B;
        localparam logic [19:0] BASE = (g == 0) ? BASE_A : BASE_B;

        logic        miso_l   = 1'b0;
        logic        sck_prev = 1'b0;
        int          nrise    = 0;
        int          nfall    = 0;
        int          n_cmds   = 0;
        logic [31:0] cmd_sr   = '0;
        logic [31:0] last_cmd = '0;

        flash_boot_loader #(
            .FLASH_OFFSET(FOFF),
            .LOAD_BASE   (BASE),
            .LOAD_LEN    (LEN),
            .CLK_DIV     (DIV)
        ) u_dut (
            .iClk    (clk),
            .iRstN   (rstn),
            .oSpiCsN (cs_n[g]),
            .oSpiSck (sck[g]),
            .oSpiMosi(mosi[g]),
            .iSpiMiso(miso_l),
            .oWrAddr (wr_addr[g]),
            .oWrData (wr_data[g]),
            .oWrEn   (wr_en[g]),
            .iWrAck  (iack_of(g)),
            .oCpuRst (cpu_rst[g]),
            .oDone   (done[g])
        );

        // SPI flash: takes 32 command bits on rising SCK, then shifts image bytes out on falling SCK.
        // Outside the data phase MISO carries noise the loader must ignore.
        always @(sck[g] or cs_n[g]) begin
            int k;
            if (cs_n[g] !== 1'b0) begin
                nrise  = 0;
                nfall  = 0;
                miso_l = 1'($urandom);
            end else if (sck[g] === 1'b1 && !sck_prev) begin
                nrise++;
                if (nrise <= 32) cmd_sr = {cmd_sr[30:0], mosi[g]};
                if (nrise == 32) begin
                    last_cmd = cmd_sr;
                    n_cmds++;
                end
            end else if (sck[g] === 1'b0 && sck_prev) begin
                nfall++;
                if (nfall < 32) begin
                    miso_l = 1'($urandom);
                end else begin
                    k      = nfall - 32;
                    miso_l = img[(int'(last_cmd[23:0]) - int'(FOFF) + k / 8) & 255][7 - (k % 8)];
                end
            end
            sck_prev = (sck[g] === 1'b1);
        end
    end

    function automatic logic iack_of(input int i);
        return ack[i];
    endfunction

    function automatic int cmds_of(input int i);
        return (i == 0) ? g_inst[0].n_cmds : g_inst[1].n_cmds;
    endfunction

    function automatic logic [31:0] cmd_of(input int i);
        return (i == 0) ? g_inst[0].last_cmd : g_inst[1].last_cmd;
    endfunction

    function automatic logic [19:0] base_of(input int i);
        return (i == 0) ? BASE_A : BASE_B;
    endfunction

    function automatic int len_of(input int i);
        return (i == 0) ? N_A : N_B;
    endfunction

    function automatic int div_of(input int i);
        return (i == 0) ? CD_A : CD_B;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_ctl"}, {cs_n[i], sck[i], mosi[i], wr_en[i], cpu_rst[i], done[i]}, 6'b100010);
            chk({tag, "_addr"}, wr_addr[i], base_of(i));
            chk({tag, "_data"}, wr_data[i], 8'h00);
        end
    endtask

    // Leaves iRstN low; run_load releases it on the negedge where the reset values were checked.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        ack  = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
    endtask

    // mode 0: ack tied high; 1: random 0..5 cycle ack delay with ack noise while idle;
    // 2: ack withheld 10 cycles on A's first byte. rst_byte >= 0 pulses reset mid-write of that byte on A.
    task automatic run_load(input int mode, input int rst_byte);
        int          c;
        int          extra;
        int          stall;
        int          exp_cmds;
        int          exp_cyc;
        int          done_cyc [2];
        int          dly [2];
        int          cmd0 [2];
        bit          pulsed;
        bit          timed_out;
        logic        legal;
        logic [7:0]  stall_dat;
        logic [19:0] exp_addr;
        logic [1:0]  prev_sck, prev_cs, prev_mosi;

        rstn      = 1'b1;
        c         = 0;
        extra     = 0;
        stall     = 0;
        pulsed    = 1'b0;
        timed_out = 1'b0;
        stall_dat = 8'h00;
        for (int i = 0; i < 2; i++) begin
            done_cyc[i] = -1;
            dly[i]      = $urandom_range(0, 5);
            cmd0[i]     = cmds_of(i);
            wcnt[i]     = 0;
        end
        prev_sck  = sck;
        prev_cs   = cs_n;
        prev_mosi = mosi;

        while (extra < 20 && !timed_out) begin
            @(negedge clk);
            c++;
            if (!rstn) begin
                chk_reset_vals("pulse");
                rstn = 1'b1;
                c    = 0;
                for (int i = 0; i < 2; i++) wcnt[i] = 0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    chk("cpu_rst_vs_done", cpu_rst[i], !done[i]);
                    if (done[i]) begin
                        if (done_cyc[i] < 0) done_cyc[i] = c;
                        chk("done_idle", {cs_n[i], sck[i], wr_en[i]}, 3'b100);
                    end
                    if (!cs_n[i] && mosi[i] !== prev_mosi[i]) begin
                        legal = prev_cs[i] || (prev_sck[i] && !sck[i]);
                        chk("mosi_edge", legal, 1'b1);
                    end
                end
                if (mode == 2 && wr_en[0] && wcnt[0] == 0) begin
                    stall++;
                    if (stall == 1) stall_dat = wr_data[0];
                    chk("stall_data", wr_data[0], stall_dat);
                    chk("stall_sck", sck[0], 1'b0);
                end
                if (rst_byte >= 0 && !pulsed && wcnt[0] == rst_byte && wr_en[0]) begin
                    rstn   = 1'b0;
                    ack    = '0;
                    pulsed = 1'b1;
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        case (mode)
                            0: ack[i] = 1'b1;
                            1: begin
                                if (wr_en[i]) begin
                                    if (dly[i] == 0) begin
                                        ack[i] = 1'b1;
                                    end else begin
                                        ack[i] = 1'b0;
                                        dly[i]--;
                                    end
                                end else begin
                                    ack[i] = 1'($urandom);
                                    dly[i] = $urandom_range(0, 5);
                                end
                            end
                            default: ack[i] = !(i == 0 && wr_en[0] && wcnt[0] == 0 && stall <= 10);
                        endcase
                        // The write completes on the coming rising edge.
                        if (wr_en[i] && ack[i]) begin
                            if (wcnt[i] < 72) wlog[i][wcnt[i]] = {wr_addr[i], wr_data[i]};
                            wcnt[i]++;
                        end
                    end
                end
            end
            if (done == 2'b11) extra++;
            if (c > 6000) begin
                chk("load_timeout", {30'b0, done}, 32'd3);
                timed_out = 1'b1;
            end
            prev_sck  = sck;
            prev_cs   = cs_n;
            prev_mosi = mosi;
        end

        for (int i = 0; i < 2; i++) begin
            chk("n_writes", wcnt[i], len_of(i));
            for (int j = 0; j < len_of(i) && j < wcnt[i] && j < 72; j++) begin
                exp_addr = base_of(i) + 20'(j);
                chk("wr_addr", wlog[i][j][27:8], exp_addr);
                chk("wr_data", wlog[i][j][7:0], img[j]);
            end
            exp_addr = base_of(i) + 20'(len_of(i));
            chk("final_addr", wr_addr[i], exp_addr);
            chk("final_ctl", {done[i], cpu_rst[i], cs_n[i], wr_en[i]}, 4'b1010);
            chk("read_cmd", cmd_of(i), {8'h03, FOFF});
            // B has only clocked ~22 command bits when A's reset pulse lands, so only A logs two commands.
            exp_cmds = 1 + ((i == 0 && pulsed) ? 1 : 0);
            chk("n_cmds", cmds_of(i) - cmd0[i], exp_cmds);
            if (mode == 0) begin
                exp_cyc = 1 + 64 * div_of(i) + len_of(i) * (16 * div_of(i) + 1);
                chk("done_cycle", done_cyc[i], exp_cyc);
            end
        end
        if (mode == 2) chk("stall_len", stall, 11);
        if (rst_byte >= 0) chk("pulse_seen", pulsed, 1'b1);
    endtask

    initial begin
        rstn = 1'b0;
        ack  = '0;
        for (int j = 0; j < 256; j++) img[j] = 8'($urandom);
        img[0] = 8'hA5;
        img[1] = 8'h3C;

        do_reset();
        run_load(0, -1);

        do_reset();
        run_load(2, -1);

        do_reset();
        run_load(0, 3);

        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 256; j++) img[j] = 8'($urandom);
            do_reset();
            run_load(1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
